alu_multicycle: RTL
===================

// Module: alu_multicycle
// PURPOSE
// - Parametrised successor ALU for the RISC-V core: XLEN-wide single-cycle integer ops plus
//   iterative MUL/DIV/REM (RV32M subset), behind valid/ready handshakes on input and output.
// - Sits between ID and WB in the single-cycle and pipelined datapaths; the stage stalls on in_ready=0.
// PARAMETERS
// - XLEN   32  operand/result width; power of two, >= 8
// - OPW    6   ALUop width
// - SHW    $clog2(XLEN)  shift-amount bits used (derived, localparam)
// PORTS
// - clk        in   1     clock; all state updates on posedge
// - rst        in   1     synchronous, active-high reset
// - in_valid   in   1     operands/op presented
// - in_ready   out  1     block can accept; transfer when in_valid & in_ready
// - ALUop      in   OPW   operation code (alu_pkg encoding)
// - oprend1    in   XLEN  source operand 1 (rs1)
// - oprend2    in   XLEN  source operand 2 (rs2 or sext imm)
// - out_valid  out  1     result held
// - out_ready  in   1     consumer takes result; transfer when out_valid & out_ready
// - result     out  XLEN  operation result
// - zero       out  1     result == 0, valid with out_valid
// - illegal    out  1     ALUop not in encoding table, valid with out_valid
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=1; out_valid=0; result=0; zero=0; illegal=0. Reset mid-operation
//   aborts the iteration; partial results are dropped, nothing emitted.
// - FSM IDLE -> (accept single-cycle op) DONE; IDLE -> (accept MUL/DIV/REM op) BUSY;
//   BUSY -> DONE after exactly XLEN iteration cycles; DONE -> (out_ready) IDLE, or DONE->DONE/BUSY
//   when out_ready and a new op is accepted in the same cycle.
// - in_ready = (state==IDLE) | (state==DONE & out_ready). Never high in BUSY.
// - Latency: op accepted at edge N -> out_valid from edge N+1 (single-cycle) or N+1+XLEN (mul/div).
//   result/zero/illegal stable while out_valid & !out_ready.
// - Single-cycle ops: add, sub (mod 2^XLEN, no overflow flag); and/or/xor; sll/srl/sra use
//   oprend2[SHW-1:0] only; slt signed, sltu unsigned -> result 0 or 1.
// - MUL: low XLEN bits of product, shift-add, one partial-product bit per cycle; sign irrelevant.
// - DIV/DIVU/REM/REMU: restoring divide, one quotient bit per cycle on magnitudes; signed
//   fixup at DONE: quotient negative iff signs differ, remainder takes dividend sign.
// - Divide by zero: quotient = all ones, remainder = oprend1 (no trap).
// - Signed overflow (-2^(XLEN-1) / -1): quotient = oprend1, remainder = 0.
// - Special cases are detected at acceptance but still take XLEN cycles (constant latency).
// - Illegal ALUop: treated as single-cycle, result=0, zero=1, illegal=1.
// - Operands are latched at acceptance; later input changes do not affect an op in flight.
// STRUCTURE
// - alu_pkg: ALUOP_* localparams (ADD 6'h01, SUB 6'h02, SLL 6'h03, AND 6'h06, OR 6'h07,
//   XOR 6'h08, SRL 6'h0B, SRA 6'h0E, SLT 6'h0F, SLTU 6'h10, MUL 6'h11, DIV 6'h13, DIVU 6'h14,
//   REM 6'h15, REMU 6'h16); state encodings S_IDLE/S_BUSY/S_DONE; is_multicycle function.
// - Sub-module alu_muldiv_iter: start/op/operands in, iteration counter, done pulse,
//   quotient/remainder/product out; top keeps handshake FSM and combinational single-cycle path.
// TESTING
// - Reset while in BUSY (mid DIV) -> next cycle out_valid=0, in_ready=1; no result emitted.
// - ADD 0x7FFFFFFF+1 -> 0x80000000 one cycle later; SUB 5-5 -> 0, zero=1; SRA 0x80000000>>33 -> 0xC0000000.
// - MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 at N+33; in_ready=0 for the whole BUSY window.
// - DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7;
//   DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
// - Back-pressure: out_ready=0 for 5 cycles after XOR -> result held stable, in_ready=0; then
//   out_ready=1 with new in_valid -> accepted same cycle, next result one cycle later.
// - ALUop 6'h3F -> result 0, zero=1, illegal=1; random ops vs. reference model, 10k vectors.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: ALUop codes, handshake FSM states and the
// operation select for the iterative multiply/divide unit.
package alu_pkg;

  localparam logic [5:0] ALUOP_ADD  = 6'h01;
  localparam logic [5:0] ALUOP_SUB  = 6'h02;
  localparam logic [5:0] ALUOP_SLL  = 6'h03;
  localparam logic [5:0] ALUOP_AND  = 6'h06;
  localparam logic [5:0] ALUOP_OR   = 6'h07;
  localparam logic [5:0] ALUOP_XOR  = 6'h08;
  localparam logic [5:0] ALUOP_SRL  = 6'h0B;
  localparam logic [5:0] ALUOP_SRA  = 6'h0E;
  localparam logic [5:0] ALUOP_SLT  = 6'h0F;
  localparam logic [5:0] ALUOP_SLTU = 6'h10;
  localparam logic [5:0] ALUOP_MUL  = 6'h11;
  localparam logic [5:0] ALUOP_DIV  = 6'h13;
  localparam logic [5:0] ALUOP_DIVU = 6'h14;
  localparam logic [5:0] ALUOP_REM  = 6'h15;
  localparam logic [5:0] ALUOP_REMU = 6'h16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    MD_MUL  = 3'd0,
    MD_DIV  = 3'd1,
    MD_DIVU = 3'd2,
    MD_REM  = 3'd3,
    MD_REMU = 3'd4
  } md_op_e;

  function automatic logic is_multicycle(input logic [5:0] op);
    return (op == ALUOP_MUL) || (op == ALUOP_DIV) || (op == ALUOP_DIVU) ||
           (op == ALUOP_REM) || (op == ALUOP_REMU);
  endfunction

  function automatic md_op_e to_md_op(input logic [5:0] op);
    case (op)
      ALUOP_DIV:  return MD_DIV;
      ALUOP_DIVU: return MD_DIVU;
      ALUOP_REM:  return MD_REM;
      ALUOP_REMU: return MD_REMU;
      default:    return MD_MUL;
    endcase
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider: one bit per cycle for XLEN cycles,
// signed fixup and divide-by-zero/overflow overrides applied on the held registers.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            done,
  output logic [XLEN-1:0] product,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, orig_q, orig_d;
  logic            mul_q, mul_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d, ovf_q, ovf_d;
  logic            signed_op, sign_a, sign_b;
  logic [XLEN:0]   trial;

  // Divide: a_q shifts the dividend out and the quotient in; acc_q is the partial remainder.
  // Multiply: a_q is the multiplier shifting right, b_q the multiplicand shifting left.
  always_comb begin
    signed_op = (op == MD_DIV) || (op == MD_REM);
    sign_a    = signed_op & opa[XLEN-1];
    sign_b    = signed_op & opb[XLEN-1];
    trial     = {acc_q, a_q[XLEN-1]} - {1'b0, b_q};
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    orig_d    = orig_q;
    mul_d     = mul_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    if (start) begin
      cnt_d     = CW'(XLEN);
      mul_d     = (op == MD_MUL);
      a_d       = sign_a ? -opa : opa;
      b_d       = sign_b ? -opb : opb;
      acc_d     = '0;
      orig_d    = opa;
      neg_quo_d = sign_a ^ sign_b;
      neg_rem_d = sign_a;
      dz_d      = (op != MD_MUL) && (opb == '0);
      ovf_d     = signed_op && (opa == MIN_NEG) && (opb == '1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (mul_q) begin
        acc_d = acc_q + (a_q[0] ? b_q : '0);
        a_d   = a_q >> 1;
        b_d   = b_q << 1;
      end else if (!trial[XLEN]) begin
        acc_d = trial[XLEN-1:0];
        a_d   = {a_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[XLEN-2:0], a_q[XLEN-1]};
        a_d   = {a_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      orig_q    <= '0;
      mul_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      orig_q    <= orig_d;
      mul_q     <= mul_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  // High during the cycle whose edge performs the final iteration.
  assign done      = (cnt_q == CW'(1));
  assign product   = acc_q;
  assign quotient  = dz_q ? '1 : (ovf_q ? orig_q : (neg_quo_q ? -a_q : a_q));
  assign remainder = dz_q ? orig_q : (ovf_q ? '0 : (neg_rem_q ? -acc_q : acc_q));

endmodule

// File: rtl/alu_multicycle.sv
// XLEN-wide ALU with valid/ready handshakes: single-cycle integer ops computed combinationally,
// MUL/DIV/REM delegated to the iterative unit.
//   state  | meaning
//   S_IDLE | empty, ready to accept
//   S_BUSY | iterative op in flight, input stalled
//   S_DONE | result held until out_ready
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  ALUop,
  input  logic [XLEN-1:0] oprend1,
  input  logic [XLEN-1:0] oprend2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  md_op_e          md_op_q, md_op_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d, illegal_q, illegal_d, md_sel_q, md_sel_d;
  logic [5:0]      op6;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sc_result, md_result, md_product, md_quotient, md_remainder;
  logic            sc_illegal, accept, op_multi, md_start, md_done;

  assign op6      = 6'(ALUop);
  assign shamt    = oprend2[SHW-1:0];
  assign op_multi = is_multicycle(op6);
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (op6)
      ALUOP_ADD:  sc_result = oprend1 + oprend2;
      ALUOP_SUB:  sc_result = oprend1 - oprend2;
      ALUOP_AND:  sc_result = oprend1 & oprend2;
      ALUOP_OR:   sc_result = oprend1 | oprend2;
      ALUOP_XOR:  sc_result = oprend1 ^ oprend2;
      ALUOP_SLL:  sc_result = oprend1 << shamt;
      ALUOP_SRL:  sc_result = oprend1 >> shamt;
      ALUOP_SRA:  sc_result = $signed(oprend1) >>> shamt;
      ALUOP_SLT:  sc_result = {{(XLEN-1){1'b0}}, $signed(oprend1) < $signed(oprend2)};
      ALUOP_SLTU: sc_result = {{(XLEN-1){1'b0}}, oprend1 < oprend2};
      default:    sc_illegal = !op_multi;
    endcase
  end

  always_comb begin
    case (md_op_q)
      MD_DIV, MD_DIVU: md_result = md_quotient;
      MD_REM, MD_REMU: md_result = md_remainder;
      default:         md_result = md_product;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    md_sel_d  = md_sel_q;
    md_op_d   = md_op_q;
    md_start  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready) state_d = S_IDLE;
        if (accept) begin
          if (op_multi) begin
            state_d  = S_BUSY;
            md_start = 1'b1;
            md_sel_d = 1'b1;
            md_op_d  = to_md_op(op6);
          end else begin
            state_d   = S_DONE;
            md_sel_d  = 1'b0;
            res_d     = sc_result;
            zero_d    = (sc_result == '0);
            illegal_d = sc_illegal;
          end
        end
      end
      S_BUSY:  if (md_done) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      res_q     <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      md_sel_q  <= 1'b0;
      md_op_q   <= MD_MUL;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      md_sel_q  <= md_sel_d;
      md_op_q   <= md_op_d;
    end
  end

  // Iterative results are read straight from the unit's registers, which hold once it finishes.
  assign out_valid = (state_q == S_DONE);
  assign result    = md_sel_q ? md_result : res_q;
  assign zero      = md_sel_q ? (md_result == '0) : zero_q;
  assign illegal   = md_sel_q ? 1'b0 : illegal_q;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .op        (md_op_d),
    .opa       (oprend1),
    .opb       (oprend2),
    .done      (md_done),
    .product   (md_product),
    .quotient  (md_quotient),
    .remainder (md_remainder)
  );

endmodule
